// File: rtl/bcd_counter_ndigit.sv
// rtl/bcd_counter_ndigit.sv - parametrised N-digit BCD up/down counter with prescaler, pause, abort and wrap
module bcd_counter_ndigit #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                abort,
  input  logic                run,
  input  logic                up_down,
  input  logic                wrap,
  input  logic [4*DIGITS-1:0] max_count,
  output logic [4*DIGITS-1:0] digits,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    target, target_nxt, digits_nxt;
  logic [W-1:0]    end_val, start_val;
  logic [PW-1:0]   presc, presc_nxt;
  logic            up_q, up_nxt, wrap_q, wrap_nxt;
  logic            done_nxt, err_nxt;
  logic            end_seen, end_seen_nxt;
  logic            tick, at_end, tgt_ok;

  function automatic logic bcd_valid(input logic [W-1:0] v);
    bcd_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bcd_valid = 1'b0;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic c;
    c = 1'b1;
    bcd_inc = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic b;
    b = 1'b1;
    bcd_dec = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      digits   <= '0;
      target   <= '0;
      presc    <= '0;
      up_q     <= 1'b0;
      wrap_q   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      end_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      digits   <= digits_nxt;
      target   <= target_nxt;
      presc    <= presc_nxt;
      up_q     <= up_nxt;
      wrap_q   <= wrap_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      end_seen <= end_seen_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    digits_nxt   = digits;
    target_nxt   = target;
    presc_nxt    = presc;
    up_nxt       = up_q;
    wrap_nxt     = wrap_q;
    done_nxt     = 1'b0;
    err_nxt      = err;
    end_seen_nxt = end_seen;

    tgt_ok    = bcd_valid(max_count);
    end_val   = up_q ? target : '0;
    start_val = up_q ? '0 : target;
    at_end    = (state == S_COUNT) && (digits == end_val);
    tick      = (state == S_COUNT) && run && (presc == PW'(TICK_DIV - 1));

    if (abort) begin
      state_nxt = S_IDLE;
    end else if (start) begin
      target_nxt   = max_count;
      up_nxt       = up_down;
      wrap_nxt     = wrap;
      presc_nxt    = '0;
      end_seen_nxt = 1'b0;
      if (!tgt_ok) begin
        err_nxt   = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        err_nxt    = 1'b0;
        digits_nxt = up_down ? '0 : max_count;
        state_nxt  = S_COUNT;
      end
    end else if (state == S_COUNT) begin
      if (run) presc_nxt = tick ? '0 : presc + 1'b1;
      if (at_end && !wrap_q) begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
      end else if (at_end) begin
        // end_seen keeps the pulse to one cycle while waiting for the reload tick
        done_nxt = !end_seen;
        if (tick) begin
          digits_nxt   = start_val;
          end_seen_nxt = 1'b0;
        end else begin
          end_seen_nxt = 1'b1;
        end
      end else if (tick) begin
        digits_nxt = up_q ? bcd_inc(digits) : bcd_dec(digits);
      end
    end
  end

  assign busy = (state == S_COUNT);

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb/tb_bcd_counter_ndigit.sv - self-checking bench with decimal reference model for bcd_counter_ndigit
module tb_bcd_counter_ndigit;

  localparam int DIGITS   = 3;
  localparam int TICK_DIV = 3;
  localparam int W        = 4 * DIGITS;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         run = 1'b0;
  logic         up_down = 1'b0;
  logic         wrap = 1'b0;
  logic [W-1:0] max_count = '0;
  logic [W-1:0] digits;
  logic         busy, done, err;

  int checks = 0;
  int failures = 0;

  int m_st, m_val, m_tgt, m_en;
  bit m_up, m_wr, m_done, m_err, m_lap;

  always #5 CLK = ~CLK;

  bcd_counter_ndigit #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .run(run),
    .up_down(up_down), .wrap(wrap), .max_count(max_count),
    .digits(digits), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int s, p;
    s = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s = s + int'(b[4*i +: 4]) * p;
      p = p * 10;
    end
    return s;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_val = 0; m_tgt = 0; m_en = 0;
    m_up = 0; m_wr = 0; m_done = 0; m_err = 0; m_lap = 0;
  endtask

  // state codes: 0 idle, 1 counting, 2 finished
  task automatic model_step();
    int e;
    bit tk;
    if (abort) begin
      m_st = 0;
      m_done = 0;
    end else if (start) begin
      m_up = up_down; m_wr = wrap; m_en = 0; m_lap = 0; m_done = 0;
      if (!bcd_ok(max_count)) begin
        m_err = 1;
        m_st = 0;
      end else begin
        m_err = 0;
        m_tgt = from_bcd(max_count);
        m_val = up_down ? 0 : m_tgt;
        m_st = 1;
      end
    end else if (m_st == 1) begin
      e = m_up ? m_tgt : 0;
      tk = run && ((m_en + 1) % TICK_DIV == 0);
      if (run) m_en++;
      m_done = 0;
      if (m_val == e) begin
        if (!m_wr) begin
          m_st = 2;
          m_done = 1;
        end else begin
          m_done = !m_lap;
          if (tk) begin
            m_val = m_up ? 0 : m_tgt;
            m_lap = 0;
          end else begin
            m_lap = 1;
          end
        end
      end else if (tk) begin
        m_val = m_up ? m_val + 1 : m_val - 1;
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic compare_all();
    chk("digits", 32'(digits), 32'(to_bcd(m_val)));
    chk("busy", 32'(busy), 32'(m_st == 1));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge CLK);
    #1;
    compare_all();
    RST = 1'b0;
  endtask

  // later values on the config inputs are scrambled to show they are ignored
  task automatic pulse_start(input logic [W-1:0] tgt, input bit up, input bit wr);
    max_count = tgt; up_down = up; wrap = wr; start = 1'b1;
    cycle();
    start = 1'b0;
    max_count = W'($urandom); up_down = 1'($urandom); wrap = 1'($urandom);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      cycle();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    logic [W-1:0] prev;
    model_reset();
    #3;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(posedge CLK);
    #1 RST = 1'b0;
    run = 1'b1;

    // count up to 37
    pulse_start(12'h037, 1'b1, 1'b0);
    wait_done(400, n);
    chk("up37_latency", 32'(n), 32'd112);
    chk("up37_value", 32'(digits), 32'h037);
    chk("up37_busy", 32'(busy), 32'h0);
    cycle();
    chk("up37_done_once", 32'(done), 32'h0);

    // count down from 12 with a 10-cycle pause
    pulse_start(12'h012, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("pause_frozen", 32'(digits), 32'h010);
    end
    run = 1'b1;
    cycle();
    chk("down_10_to_09", 32'(digits), 32'h009);
    wait_done(200, n);
    chk("down12_latency", 32'(n), 32'd28);
    chk("down12_value", 32'(digits), 32'h000);

    // three-digit carry 099 -> 100
    pulse_start(12'h105, 1'b1, 1'b0);
    n = 0;
    while (!done && n < 500) begin
      prev = digits;
      cycle();
      n++;
      if (prev == 12'h099 && digits != 12'h099) chk("carry_099_100", 32'(digits), 32'h100);
    end
    chk("up105_latency", 32'(n), 32'd316);

    // wrap mode 0..9
    pulse_start(12'h009, 1'b1, 1'b1);
    wait_done(200, n);
    chk("wrap_first", 32'(n), 32'd28);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!done && n < 200);
    chk("wrap_period", 32'(n), 32'd30);
    chk("wrap_busy", 32'(busy), 32'h1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;

    // invalid target then valid target
    prev = digits;
    pulse_start(12'h03A, 1'b1, 1'b0);
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_busy", 32'(busy), 32'h0);
    chk("bad_hold", 32'(digits), 32'(prev));
    pulse_start(12'h005, 1'b1, 1'b0);
    chk("good_err", 32'(err), 32'h0);
    chk("good_busy", 32'(busy), 32'h1);

    // reset mid-count, then abort mid-count
    pulse_start(12'h099, 1'b1, 1'b0);
    n = 0;
    while (digits != 12'h021 && n < 200) begin cycle(); n++; end
    chk("reach21_a", 32'(digits), 32'h021);
    do_reset();
    chk("rst_mid_digits", 32'(digits), 32'h0);
    pulse_start(12'h099, 1'b1, 1'b0);
    n = 0;
    while (digits != 12'h021 && n < 200) begin cycle(); n++; end
    chk("reach21_b", 32'(digits), 32'h021);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_hold", 32'(digits), 32'h021);
    chk("abort_done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) cycle();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 30 == 0);
      abort = ($urandom % 90 == 0);
      run = ($urandom % 8 != 0);
      up_down = 1'($urandom);
      wrap = 1'($urandom);
      if (start) begin
        max_count[3:0]  = ($urandom % 12 == 0) ? 4'hB : 4'($urandom % 10);
        max_count[7:4]  = ($urandom % 20 == 0) ? 4'hF : 4'($urandom % 3);
        max_count[11:8] = ($urandom % 5 == 0) ? 4'h1 : 4'h0;
      end else begin
        max_count = W'($urandom);
      end
      if ($urandom % 700 == 0) begin
        start = 1'b0;
        abort = 1'b0;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
